// File: rtl/param_router_arbiter.sv
// Five-port mesh router arbiter. It computes XY routes, runs one credit-gated
// arbiter per output and registers the grants, with a one-cycle input lockout.

module param_router_arbiter_out #(
    parameter int CREDIT_MAX = 4,
    parameter int ARB_MODE   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    input  logic       credit,
    output logic [4:0] gnt,
    output logic [2:0] src,
    output logic [3:0] cnt
);
    localparam logic [3:0] CMAX = 4'(CREDIT_MAX);

    logic [2:0] ptr;
    logic       any;
    int         idx;

    // The search starts at ptr in round-robin mode and at 0 in fixed-priority mode.
    always_comb begin
        gnt = '0;
        src = '0;
        any = 1'b0;
        idx = 0;
        if (cnt != 4'd0) begin
            for (int i = 0; i < 5; i++) begin
                idx = (ARB_MODE == 0) ? int'(ptr) + i : i;
                if (idx >= 5) idx = idx - 5;
                if (!any && req[idx]) begin
                    any      = 1'b1;
                    gnt[idx] = 1'b1;
                    src      = 3'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= CMAX;
            ptr <= '0;
        end else begin
            if (any && !credit)
                cnt <= cnt - 4'd1;
            else if (!any && credit && cnt != CMAX)
                cnt <= cnt + 4'd1;
            if (ARB_MODE == 0 && any)
                ptr <= (src == 3'd4) ? 3'd0 : src + 3'd1;
        end
    end
endmodule

module param_router_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int CREDIT_MAX = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int ARB_MODE   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5*ADDR_W-1:0] address_i,
    input  logic [4:0]          empty_i,
    input  logic [4:0]          credit_i,
    output logic [4:0]          read_o,
    output logic [4:0]          dec_o,
    output logic [14:0]         mux_sel_o,
    output logic [14:0]         demux_sel_o,
    output logic [19:0]         credit_cnt_o
);
    localparam int HW = ADDR_W / 2;
    localparam logic [HW-1:0] MX = HW'(MY_X);
    localparam logic [HW-1:0] MYC = HW'(MY_Y);

    logic [4:0][2:0] route;
    logic [4:0][4:0] req;   // [output][input]
    logic [4:0][4:0] gnt;   // [output][input]
    logic [4:0][2:0] src;
    logic [4:0][3:0] cnt;
    logic [4:0]      take;
    logic [4:0][2:0] mux_sel;
    logic [4:0][2:0] demux_sel;

    for (genvar p = 0; p < 5; p++) begin : g_in
        logic [HW-1:0] dx, dy;
        assign dx = address_i[p*ADDR_W+HW +: HW];
        assign dy = address_i[p*ADDR_W +: HW];
        assign route[p] = (dx > MX)  ? 3'd2 :
                          (dx < MX)  ? 3'd3 :
                          (dy > MYC) ? 3'd0 :
                          (dy < MYC) ? 3'd1 : 3'd4;
    end

    // read_o doubles as the lockout: an input popped last cycle may still show a stale head.
    for (genvar q = 0; q < 5; q++) begin : g_out
        for (genvar p = 0; p < 5; p++) begin : g_req
            assign req[q][p] = !empty_i[p] && !read_o[p] && (route[p] == 3'(q));
        end
        param_router_arbiter_out #(
            .CREDIT_MAX(CREDIT_MAX),
            .ARB_MODE  (ARB_MODE)
        ) u_out (
            .clk   (clk),
            .reset (reset),
            .req   (req[q]),
            .credit(credit_i[q]),
            .gnt   (gnt[q]),
            .src   (src[q]),
            .cnt   (cnt[q])
        );
        assign credit_cnt_o[q*4 +: 4] = cnt[q];
    end

    always_comb begin
        take = '0;
        for (int q = 0; q < 5; q++) take = take | gnt[q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_o    <= '0;
            dec_o     <= '0;
            mux_sel   <= '0;
            demux_sel <= '0;
        end else begin
            read_o <= take;
            for (int q = 0; q < 5; q++) begin
                dec_o[q]   <= |gnt[q];
                mux_sel[q] <= src[q];
            end
            for (int p = 0; p < 5; p++)
                demux_sel[p] <= take[p] ? route[p] : 3'd0;
        end
    end

    assign mux_sel_o   = mux_sel;
    assign demux_sel_o = demux_sel;
endmodule

// File: tb/tb_param_router_arbiter.sv
// Bench for param_router_arbiter. Three instances share one stimulus, and every
// cycle each instance is checked against a per-instance behavioural model.

module tb_param_router_arbiter;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] address;
    logic [4:0]  empty, credit;
    logic [4:0]  rd   [NI];
    logic [4:0]  dc   [NI];
    logic [14:0] mux  [NI];
    logic [14:0] dmx  [NI];
    logic [19:0] cnt  [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_router_arbiter #(.ADDR_W(8), .CREDIT_MAX(4), .MY_X(2), .MY_Y(2), .ARB_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .address_i(address), .empty_i(empty), .credit_i(credit),
        .read_o(rd[0]), .dec_o(dc[0]), .mux_sel_o(mux[0]), .demux_sel_o(dmx[0]), .credit_cnt_o(cnt[0]));
    param_router_arbiter #(.ADDR_W(8), .CREDIT_MAX(2), .MY_X(2), .MY_Y(2), .ARB_MODE(0)) dut1 (
        .clk(clk), .reset(reset), .address_i(address), .empty_i(empty), .credit_i(credit),
        .read_o(rd[1]), .dec_o(dc[1]), .mux_sel_o(mux[1]), .demux_sel_o(dmx[1]), .credit_cnt_o(cnt[1]));
    param_router_arbiter #(.ADDR_W(8), .CREDIT_MAX(3), .MY_X(2), .MY_Y(2), .ARB_MODE(1)) dut2 (
        .clk(clk), .reset(reset), .address_i(address), .empty_i(empty), .credit_i(credit),
        .read_o(rd[2]), .dec_o(dc[2]), .mux_sel_o(mux[2]), .demux_sel_o(dmx[2]), .credit_cnt_o(cnt[2]));

    function automatic int cm_of(int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 3;
    endfunction

    function automatic int am_of(int k);
        return (k == 2) ? 1 : 0;
    endfunction

    // XY route for a router sitting at (2,2).
    function automatic int route_of(logic [7:0] a);
        int x, y;
        x = int'(a[7:4]);
        y = int'(a[3:0]);
        if (x > 2) return 2;
        if (x < 2) return 3;
        if (y > 2) return 0;
        if (y < 2) return 1;
        return 4;
    endfunction

    // Model state: credits, arbitration pointers, the inputs popped last cycle, and expected outputs.
    int          m_cred [NI][5];
    int          m_ptr  [NI][5];
    bit          m_last [NI][5];
    logic [4:0]  e_rd   [NI];
    logic [4:0]  e_dc   [NI];
    logic [14:0] e_mux  [NI];
    logic [14:0] e_dmx  [NI];

    task automatic model_step();
        int g [5];
        int p;
        logic [7:0] a;
        for (int k = 0; k < NI; k++) begin
            e_rd[k] = '0; e_dc[k] = '0; e_mux[k] = '0; e_dmx[k] = '0;
            if (reset) begin
                for (int q = 0; q < 5; q++) begin
                    m_cred[k][q] = cm_of(k);
                    m_ptr[k][q]  = 0;
                    m_last[k][q] = 1'b0;
                end
            end else begin
                for (int q = 0; q < 5; q++) begin
                    g[q] = -1;
                    if (m_cred[k][q] > 0) begin
                        for (int i = 0; i < 5; i++) begin
                            p = (am_of(k) == 0) ? (m_ptr[k][q] + i) % 5 : i;
                            a = address[p*8 +: 8];
                            if (g[q] < 0 && !empty[p] && !m_last[k][p] && route_of(a) == q)
                                g[q] = p;
                        end
                    end
                end
                for (int q = 0; q < 5; q++) begin
                    if (g[q] >= 0) begin
                        e_rd[k][g[q]]        = 1'b1;
                        e_dc[k][q]           = 1'b1;
                        e_mux[k][q*3 +: 3]   = 3'(g[q]);
                        e_dmx[k][g[q]*3 +: 3] = 3'(q);
                        if (am_of(k) == 0) m_ptr[k][q] = (g[q] + 1) % 5;
                    end
                    if (g[q] >= 0 && !credit[q])
                        m_cred[k][q] = m_cred[k][q] - 1;
                    else if (g[q] < 0 && credit[q] && m_cred[k][q] < cm_of(k))
                        m_cred[k][q] = m_cred[k][q] + 1;
                end
                for (int q = 0; q < 5; q++) m_last[k][q] = e_rd[k][q];
            end
        end
    endtask

    task automatic check(string name, logic [19:0] act, logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [19:0] ec;
        for (int k = 0; k < NI; k++) begin
            ec = '0;
            for (int q = 0; q < 5; q++) ec[q*4 +: 4] = 4'(m_cred[k][q]);
            check($sformatf("dut%0d read_o", k),      20'(rd[k]),  20'(e_rd[k]));
            check($sformatf("dut%0d dec_o", k),       20'(dc[k]),  20'(e_dc[k]));
            check($sformatf("dut%0d mux_sel_o", k),   20'(mux[k]), 20'(e_mux[k]));
            check($sformatf("dut%0d demux_sel_o", k), 20'(dmx[k]), 20'(e_dmx[k]));
            check($sformatf("dut%0d credit_cnt_o", k), cnt[k],     ec);
        end
    endtask

    // One clock: the model follows the edge, then all instances are compared.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; empty = 5'h1f; credit = '0;
        tick();
        reset = 1'b0;
    endtask

    int pulses;
    logic [4:0] rr_rd [5];
    logic [2:0] rr_src [5];
    logic [4:0] fp_rd [4];
    logic [2:0] fp_src [4];

    initial begin
        reset = 1'b1; empty = 5'h1f; credit = '0; address = '0;
        rr_rd  = '{5'b00001, 5'b00010, 5'b01000, 5'b10000, 5'b00001};
        rr_src = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd0};
        fp_rd  = '{5'b00001, 5'b01000, 5'b00001, 5'b01000};
        fp_src = '{3'd0, 3'd3, 3'd0, 3'd3};
        tick(); tick();
        reset = 1'b0;
        check("reset read_o", 20'(rd[0]), 20'h0);
        check("reset cnt dut0", cnt[0], 20'h44444);
        check("reset cnt dut1", cnt[1], 20'h22222);
        check("reset cnt dut2", cnt[2], 20'h33333);

        // Routing from the local port.
        address[32 +: 8] = 8'h32; empty = 5'b01111; tick();
        check("route 32 demux", 20'(dmx[0][14:12]), 20'd2);
        check("route 32 read", 20'(rd[0]), 20'b10000);
        empty = 5'h1f; tick();
        address[32 +: 8] = 8'h22; empty = 5'b01111; tick();
        check("route 22 demux", 20'(dmx[0][14:12]), 20'd4);
        empty = 5'h1f; tick();
        address[32 +: 8] = 8'h21; empty = 5'b01111; tick();
        check("route 21 demux", 20'(dmx[0][14:12]), 20'd1);
        empty = 5'h1f; tick();

        // Round-robin: N, S, W and L all heading east.
        do_reset();
        address = {8'h32, 8'h32, 8'h00, 8'h32, 8'h32};
        empty = 5'b00100; credit = 5'b00100;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr read %0d", i), 20'(rd[0]), 20'(rr_rd[i]));
            check($sformatf("rr src %0d", i), 20'(mux[0][8:6]), 20'(rr_src[i]));
        end
        empty = 5'h1f; credit = '0; tick();

        // Credit exhaustion on the two-deep instance.
        do_reset();
        address[32 +: 8] = 8'h32; empty = 5'b01111;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin tick(); pulses += int'(dc[1][2]); end
        check("exhaust pulses", 20'(pulses), 20'd2);
        check("exhaust cnt", 20'(cnt[1][11:8]), 20'd0);
        credit = 5'b00100; pulses = 0;
        tick(); pulses += int'(dc[1][2]);
        credit = '0;
        for (int i = 0; i < 8; i++) begin tick(); pulses += int'(dc[1][2]); end
        check("refill pulses", 20'(pulses), 20'd1);

        // Grant and credit return in the same cycle, then saturation.
        empty = 5'h1f; credit = 5'b00100; tick();
        check("cnt one", 20'(cnt[1][11:8]), 20'd1);
        empty = 5'b01111; credit = 5'b00100; tick();
        check("both dec", 20'(dc[1][2]), 20'd1);
        check("both cnt", 20'(cnt[1][11:8]), 20'd1);
        empty = 5'h1f; credit = '0; tick();
        do_reset();
        credit = 5'h1f; tick();
        check("sat dut0", cnt[0], 20'h44444);
        check("sat dut1", cnt[1], 20'h22222);
        credit = '0;

        // Fixed priority: inputs 0 and 3 both heading west.
        do_reset();
        address = {8'h00, 8'h12, 8'h00, 8'h00, 8'h12};
        empty = 5'b10110; credit = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("fp read %0d", i), 20'(rd[2]), 20'(fp_rd[i]));
            check($sformatf("fp src %0d", i), 20'(mux[2][11:9]), 20'(fp_src[i]));
        end
        empty = 5'h1f; credit = '0; tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 5; p++) begin
                address[p*8 +: 8] = {4'($urandom_range(1, 3)), 4'($urandom_range(1, 3))};
                empty[p]  = ($urandom_range(0, 3) == 0);
                credit[p] = ($urandom_range(0, 9) < 3);
            end
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;

        // Reset lands in the cycle after a decision.
        do_reset();
        address = {8'h32, 8'h00, 8'h00, 8'h00, 8'h32};
        empty = 5'b01110; tick();
        check("pre-reset dec", 20'(dc[0][2]), 20'd1);
        reset = 1'b1; tick();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("midrst read %0d", k), 20'(rd[k]), 20'h0);
            check($sformatf("midrst dec %0d", k), 20'(dc[k]), 20'h0);
        end
        check("midrst cnt dut0", cnt[0], 20'h44444);
        check("midrst cnt dut1", cnt[1], 20'h22222);
        check("midrst cnt dut2", cnt[2], 20'h33333);
        reset = 1'b0; empty = 5'h1f; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
